// File: rtl/nvdla_pdp_reg_initiator_pkg.sv
// rtl/nvdla_pdp_reg_initiator_pkg.sv - shared op codes, offsets, field positions and FSM states
package nvdla_pdp_reg_initiator_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FLIP  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_POLL,
    S_WRITE,
    S_RESP
  } state_e;

  localparam logic [11:0] STATUS_OFFS_DEF  = 12'h000;
  localparam logic [11:0] POINTER_OFFS_DEF = 12'h004;

  localparam int STATUS0_LSB  = 0;
  localparam int STATUS1_LSB  = 16;
  localparam int STATUS_W     = 2;
  localparam int PRODUCER_BIT = 0;

  // A group is idle once its 2-bit status field reads back as zero.
  function automatic logic group_idle(input logic [31:0] status, input logic g);
    if (g) return status[STATUS1_LSB +: STATUS_W] == '0;
    return status[STATUS0_LSB +: STATUS_W] == '0;
  endfunction

endpackage

// File: rtl/nvdla_pdp_reg_initiator_if.sv
// rtl/nvdla_pdp_reg_initiator_if.sv - host command/response channels plus register bus
interface nvdla_pdp_reg_initiator_if;
  logic        req_pvld;
  logic        req_prdy;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdat;
  logic        rsp_pvld;
  logic        rsp_prdy;
  logic [31:0] rsp_rdat;
  logic        rsp_err;
  logic [11:0] reg_offset;
  logic        reg_wr_en;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data;

  modport master (
    input  req_pvld, req_op, req_addr, req_wdat, rsp_prdy, reg_rd_data,
    output req_prdy, rsp_pvld, rsp_rdat, rsp_err, reg_offset, reg_wr_en, reg_wr_data
  );

  modport slave (
    output req_pvld, req_op, req_addr, req_wdat, rsp_prdy, reg_rd_data,
    input  req_prdy, rsp_pvld, rsp_rdat, rsp_err, reg_offset, reg_wr_en, reg_wr_data
  );
endinterface

// File: rtl/nvdla_pdp_reg_initiator.sv
// rtl/nvdla_pdp_reg_initiator.sv - one register access per host command, with status-polling flip
module nvdla_pdp_reg_initiator
  import nvdla_pdp_reg_initiator_pkg::*;
#(
  parameter int          POLL_MAX     = 16,
  parameter logic [11:0] STATUS_OFFS  = STATUS_OFFS_DEF,
  parameter logic [11:0] POINTER_OFFS = POINTER_OFFS_DEF
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  nvdla_pdp_reg_initiator_if.master   bus
);

  state_e      state_q;
  logic        is_rd_q;
  logic        g_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        rsp_pvld_q;
  logic [31:0] rsp_rdat_q;
  logic        rsp_err_q;
  logic [11:0] reg_offset_q;
  logic        reg_wr_en_q;
  logic [31:0] reg_wr_data_q;
  op_e         req_op;

  assign req_op = op_e'(bus.req_op);
  assign cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q       <= S_IDLE;
      is_rd_q       <= 1'b0;
      g_q           <= 1'b0;
      cnt_q         <= '0;
      rsp_pvld_q    <= 1'b0;
      rsp_rdat_q    <= '0;
      rsp_err_q     <= 1'b0;
      reg_offset_q  <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_pvld) begin
            is_rd_q <= (req_op == OP_READ);
            g_q     <= bus.req_wdat[PRODUCER_BIT];
            cnt_q   <= '0;
            case (req_op)
              OP_READ, OP_WRITE: begin
                reg_offset_q  <= bus.req_addr;
                reg_wr_en_q   <= (req_op == OP_WRITE);
                reg_wr_data_q <= (req_op == OP_WRITE) ? bus.req_wdat : '0;
                state_q       <= S_ACCESS;
              end
              OP_FLIP: begin
                reg_offset_q <= STATUS_OFFS;
                state_q      <= S_POLL;
              end
              default: begin
                rsp_pvld_q <= 1'b1;
                rsp_err_q  <= 1'b1;
                rsp_rdat_q <= '0;
                state_q    <= S_RESP;
              end
            endcase
          end
        end
        S_ACCESS: begin
          rsp_rdat_q    <= is_rd_q ? bus.reg_rd_data : '0;
          rsp_err_q     <= 1'b0;
          rsp_pvld_q    <= 1'b1;
          reg_offset_q  <= '0;
          reg_wr_en_q   <= 1'b0;
          reg_wr_data_q <= '0;
          state_q       <= S_RESP;
        end
        S_POLL: begin
          // The last status read is reported back whether the flip completes or times out.
          if (group_idle(bus.reg_rd_data, g_q)) begin
            rsp_rdat_q    <= bus.reg_rd_data;
            reg_offset_q  <= POINTER_OFFS;
            reg_wr_en_q   <= 1'b1;
            reg_wr_data_q <= {31'b0, g_q};
            state_q       <= S_WRITE;
          end else if (cnt_q == 8'(POLL_MAX - 1)) begin
            rsp_rdat_q   <= bus.reg_rd_data;
            rsp_err_q    <= 1'b1;
            rsp_pvld_q   <= 1'b1;
            reg_offset_q <= '0;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WRITE: begin
          reg_offset_q  <= '0;
          reg_wr_en_q   <= 1'b0;
          reg_wr_data_q <= '0;
          rsp_err_q     <= 1'b0;
          rsp_pvld_q    <= 1'b1;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_prdy) begin
            rsp_pvld_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_rdat_q <= '0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ready is withheld while reset is held so no command slips in during reset.
  assign bus.req_prdy    = (state_q == S_IDLE) && !nvdla_core_rst;
  assign bus.rsp_pvld    = rsp_pvld_q;
  assign bus.rsp_rdat    = rsp_rdat_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.reg_offset  = reg_offset_q;
  assign bus.reg_wr_en   = reg_wr_en_q;
  assign bus.reg_wr_data = reg_wr_data_q;

endmodule

// File: tb/tb_nvdla_pdp_reg_initiator.sv
// tb/tb_nvdla_pdp_reg_initiator.sv - table-driven and randomized checks of the PDP register initiator
module tb_nvdla_pdp_reg_initiator;

  localparam int PM = 4;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdat;
    int          busy;
    int          dly;
    logic [31:0] rdval;
    logic [31:0] busy_val;
    logic [31:0] idle_val;
    logic [31:0] e_rdat;
    logic        e_err;
    int          e_lat;
    int          e_wr;
    logic [31:0] e_wdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] status_val = '0;
  logic [31:0] rd_val = '0;
  int          tests = 0;
  int          fails = 0;

  nvdla_pdp_reg_initiator_if bus();

  nvdla_pdp_reg_initiator #(.POLL_MAX(PM)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  always_comb bus.reg_rd_data = (bus.reg_offset == 12'h000) ? status_val : rd_val;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdat,
                               input int busy, input int dly, input logic [31:0] rdval,
                               input logic [31:0] bv, input logic [31:0] iv, input logic [31:0] e_rdat,
                               input logic e_err, input int e_lat, input int e_wr, input logic [31:0] e_wdata);
    vec_t v;
    v.op = op; v.addr = addr; v.wdat = wdat; v.busy = busy; v.dly = dly; v.rdval = rdval;
    v.busy_val = bv; v.idle_val = iv; v.e_rdat = e_rdat; v.e_err = e_err;
    v.e_lat = e_lat; v.e_wr = e_wr; v.e_wdata = e_wdata;
    return v;
  endfunction

  // Reference: expected response, latency and write outcome straight from the command rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.e_err = 1'b0; r.e_rdat = '0; r.e_wr = 0; r.e_wdata = '0;
    case (v.op)
      2'd0: begin r.e_rdat = v.rdval; r.e_lat = 2; end
      2'd1: begin r.e_lat = 2; r.e_wr = 1; r.e_wdata = v.wdat; end
      2'd2: begin
        if (v.busy < PM) begin
          r.e_lat = 3 + v.busy; r.e_wr = 1; r.e_wdata = {31'b0, v.wdat[0]}; r.e_rdat = v.idle_val;
        end else begin
          r.e_lat = 1 + PM; r.e_err = 1'b1; r.e_rdat = v.busy_val;
        end
      end
      default: begin r.e_lat = 1; r.e_err = 1'b1; end
    endcase
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic g;
    logic [1:0] f;
    v.op = 2'($urandom_range(0, 3));
    v.addr = 12'($urandom_range(1, 4095));
    v.wdat = $urandom;
    v.busy = $urandom_range(0, 5);
    v.dly = $urandom_range(0, 2);
    v.rdval = $urandom;
    g = v.wdat[0];
    f = 2'($urandom_range(1, 3));
    v.busy_val = $urandom;
    v.idle_val = $urandom;
    if (g) begin v.busy_val[17:16] = f; v.idle_val[17:16] = 2'b00; end
    else begin v.busy_val[1:0] = f; v.idle_val[1:0] = 2'b00; end
    return model(v);
  endfunction

  task automatic run(input vec_t v, input string nm);
    int c;
    int seen;
    int wrs;
    logic [31:0] wd_seen;
    logic [11:0] exp_off;
    logic bad_off, bad_wd, bad_prdy, bad_hold;
    logic [31:0] r;
    logic e;
    c = 0;
    while (!bus.req_prdy && c < 20) begin tick(); c++; end
    chk({nm, " req_prdy"}, 32'(bus.req_prdy), 32'd1);
    bus.req_pvld = 1'b1; bus.req_op = v.op; bus.req_addr = v.addr; bus.req_wdat = v.wdat;
    rd_val = v.rdval;
    tick();
    bus.req_pvld = 1'b0; bus.req_op = 2'($urandom); bus.req_addr = 12'($urandom); bus.req_wdat = $urandom;
    c = 1; seen = 0; wrs = 0; wd_seen = '0;
    bad_off = 1'b0; bad_wd = 1'b0; bad_prdy = 1'b0;
    while (seen == 0 && c <= 40) begin
      status_val = (c - 1 < v.busy) ? v.busy_val : v.idle_val;
      if ((v.op == 2'd0 || v.op == 2'd1) && c == 1) exp_off = v.addr;
      else if (v.op == 2'd2 && v.e_wr > 0 && c == v.e_lat - 1) exp_off = 12'h004;
      else exp_off = 12'h000;
      if (bus.reg_offset !== exp_off) bad_off = 1'b1;
      if (bus.reg_wr_en) begin wrs++; wd_seen = bus.reg_wr_data; end
      else if (bus.reg_wr_data !== '0) bad_wd = 1'b1;
      if (bus.req_prdy) bad_prdy = 1'b1;
      if (bus.rsp_pvld) seen = c;
      else begin tick(); c++; end
    end
    chk({nm, " latency"}, 32'(seen), 32'(v.e_lat));
    chk({nm, " wr_pulses"}, 32'(wrs), 32'(v.e_wr));
    if (v.e_wr > 0) chk({nm, " wr_data"}, wd_seen, v.e_wdata);
    chk({nm, " bus_offset"}, 32'(bad_off), 32'd0);
    chk({nm, " idle_wdata_zero"}, 32'(bad_wd), 32'd0);
    chk({nm, " busy_no_ready"}, 32'(bad_prdy), 32'd0);
    chk({nm, " rsp_rdat"}, bus.rsp_rdat, v.e_rdat);
    chk({nm, " rsp_err"}, 32'(bus.rsp_err), 32'(v.e_err));
    r = bus.rsp_rdat; e = bus.rsp_err; bad_hold = 1'b0;
    for (int j = 0; j < v.dly; j++) begin
      tick();
      if (!bus.rsp_pvld || bus.rsp_rdat !== r || bus.rsp_err !== e || bus.req_prdy || bus.reg_wr_en)
        bad_hold = 1'b1;
    end
    if (v.dly > 0) chk({nm, " rsp_hold"}, 32'(bad_hold), 32'd0);
    bus.rsp_prdy = 1'b1;
    tick();
    bus.rsp_prdy = 1'b0;
    chk({nm, " rsp_done"}, {30'b0, bus.rsp_pvld, bus.req_prdy}, 32'd1);
    status_val = '0;
  endtask

  vec_t tbl[7];
  vec_t v;
  int   wr_seen;

  initial begin
    bus.req_pvld = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdat = '0; bus.rsp_prdy = 1'b0;

    tbl[0] = mkv(2'd0, 12'h004, 32'h0,         0, 0, 32'h0001_0001, 32'h0,         32'h0,
                 32'h0001_0001, 1'b0, 2, 0, 32'h0);
    tbl[1] = mkv(2'd1, 12'h004, 32'h1,         0, 3, 32'h5555_AAAA, 32'h0,         32'h0,
                 32'h0,         1'b0, 2, 1, 32'h1);
    tbl[2] = mkv(2'd2, 12'h000, 32'h1,         0, 0, 32'h0,         32'h0,         32'h0000_0002,
                 32'h0000_0002, 1'b0, 3, 1, 32'h1);
    tbl[3] = mkv(2'd2, 12'h000, 32'h0,         3, 1, 32'h0,         32'h0000_0001, 32'h0000_0000,
                 32'h0,         1'b0, 6, 1, 32'h0);
    tbl[4] = mkv(2'd2, 12'h000, 32'h1,         4, 0, 32'h0,         32'h0003_0000, 32'h0,
                 32'h0003_0000, 1'b1, 5, 0, 32'h0);
    tbl[5] = mkv(2'd3, 12'h7FC, 32'hFFFF_FFFF, 0, 2, 32'h1234_5678, 32'h0,         32'h0,
                 32'h0,         1'b1, 1, 0, 32'h0);
    tbl[6] = mkv(2'd1, 12'hFFF, 32'hDEAD_BEEF, 0, 0, 32'h0,         32'h0,         32'h0,
                 32'h0,         1'b0, 2, 1, 32'hDEAD_BEEF);

    tick(); tick();
    chk("reset req_prdy", 32'(bus.req_prdy), 32'd0);
    chk("reset rsp", {bus.rsp_rdat[30:0], bus.rsp_pvld}, 32'd0);
    chk("reset bus", {bus.reg_wr_en, 7'b0, bus.reg_offset, 12'b0} | bus.reg_wr_data | 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset req_prdy", 32'(bus.req_prdy), 32'd1);

    for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Reset while polling a busy group: no pointer write may follow.
    wr_seen = 0;
    bus.req_pvld = 1'b1; bus.req_op = 2'd2; bus.req_wdat = 32'h0; status_val = 32'h0000_0003;
    tick();
    bus.req_pvld = 1'b0;
    for (int i = 0; i < 2; i++) begin if (bus.reg_wr_en) wr_seen++; tick(); end
    rst = 1'b1;
    tick();
    chk("midpoll reset outputs", {bus.reg_wr_data[30:0], bus.reg_wr_en} | {20'b0, bus.reg_offset} | bus.rsp_rdat
        | {30'b0, bus.rsp_pvld, bus.rsp_err}, 32'd0);
    chk("midpoll reset req_prdy", 32'(bus.req_prdy), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("midpoll after reset req_prdy", 32'(bus.req_prdy), 32'd1);
    for (int i = 0; i < 4; i++) begin if (bus.reg_wr_en || bus.rsp_pvld) wr_seen++; tick(); end
    chk("midpoll no write or response", 32'(wr_seen), 32'd0);
    status_val = '0;

    for (int i = 0; i < 40; i++) begin
      v = rand_vec();
      run(v, $sformatf("rnd%0d_op%0d", i, v.op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
